escalado_scan_ctrl: RTL and testbench

//  Control unit upstream of the datapath sequencing FSM in the bilinear downscaler. Per output pixel it:
//  - steps a fixed-point source position and fetches the 4 neighbour pixels from source memory;
//  - drives dp_iniciar and waits for dp_listo;
//  - writes dp_resultado to destination memory.
//  It finishes when the whole dst_w x dst_h frame is written.

---
 rtl/escalado_scan_ctrl_if.sv | 41 ++++
 rtl/escalado_scan_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_escalado_scan_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/escalado_scan_ctrl_if.sv
// Memory and datapath bus between the scan controller and its neighbours.
// The controller owns the master side.
interface escalado_scan_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int FRAC_W = 8
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [7:0]        p00;
  logic [7:0]        p01;
  logic [7:0]        p10;
  logic [7:0]        p11;
  logic [FRAC_W-1:0] fx;
  logic [FRAC_W-1:0] fy;
  logic              dp_iniciar;
  logic              dp_ocupado;
  logic              dp_listo;
  logic [7:0]        dp_resultado;

  modport master (
    output rd_en, rd_addr,
    input  rd_data,
    output wr_en, wr_addr, wr_data,
    output p00, p01, p10, p11, fx, fy,
    output dp_iniciar,
    input  dp_ocupado, dp_listo, dp_resultado
  );

  modport slave (
    input  rd_en, rd_addr,
    output rd_data,
    input  wr_en, wr_addr, wr_data,
    input  p00, p01, p10, p11, fx, fy,
    input  dp_iniciar,
    output dp_ocupado, dp_listo, dp_resultado
  );
endinterface

// File: rtl/escalado_scan_ctrl.sv
// Bilinear downscaler scan controller: walks the destination frame,
// fetches 4 source neighbours per pixel, runs the datapath, writes back.
module escalado_scan_ctrl #(
  parameter int DIM_W  = 10,
  parameter int FRAC_W = 8,
  parameter int ADDR_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [DIM_W-1:0]        src_w,
  input  logic [DIM_W-1:0]        src_h,
  input  logic [DIM_W-1:0]        dst_w,
  input  logic [DIM_W-1:0]        dst_h,
  input  logic [DIM_W+FRAC_W-1:0] step_x,
  input  logic [DIM_W+FRAC_W-1:0] step_y,
  input  logic [ADDR_W-1:0]       src_base,
  input  logic [ADDR_W-1:0]       dst_base,
  output logic                    busy,
  output logic                    done,
  escalado_scan_ctrl_if.master    bus
);

  localparam int STEP_W = DIM_W + FRAC_W;
  localparam int ACC_W  = 2 * DIM_W + FRAC_W;
  localparam int IW     = ACC_W - FRAC_W;

  typedef enum logic [3:0] {
    S_IDLE, S_ZERO,
    S_RD00, S_RD01, S_RD10, S_RD11, S_CAP,
    S_ISSUE, S_WAIT, S_WRITE, S_NEXT
  } state_t;

  state_t state, nxt;

  logic [DIM_W-1:0]  src_w_q, src_h_q;
  logic [DIM_W-1:0]  dst_w_q, dst_h_q;
  logic [STEP_W-1:0] step_x_q, step_y_q;
  logic [ADDR_W-1:0] src_base_q, dst_base_q;
  logic [DIM_W-1:0]  ox, oy;
  logic [ACC_W-1:0]  acc_x, acc_y;
  logic [ADDR_W-1:0] pix;
  logic [7:0]        p00_q, p01_q, p10_q, p11_q;
  logic [7:0]        wr_data_q;

  logic              last_col, last_row, zero_sz;
  logic              res_ok;
  logic [DIM_W-1:0]  xmax, ymax;
  logic [DIM_W-1:0]  ix, iy, x1, y1;
  logic [DIM_W-1:0]  rx, ry;
  logic [IW-1:0]     prod;
  logic              rd_st, sel_x1, sel_y1;

  function automatic logic [DIM_W-1:0] clamp(
    input logic [IW-1:0]    v,
    input logic [DIM_W-1:0] mx
  );
    return (v > IW'(mx)) ? mx : v[DIM_W-1:0];
  endfunction

  assign last_col = (ox == dst_w_q - DIM_W'(1));
  assign last_row = (oy == dst_h_q - DIM_W'(1));
  assign zero_sz  = (dst_w == '0) || (dst_h == '0);
  // a listo seen while still busy belongs to the previous job
  assign res_ok   = bus.dp_listo && !bus.dp_ocupado;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt  = state;
    done = 1'b0;
    if (abort) begin
      nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) nxt = zero_sz ? S_ZERO : S_RD00;
        S_ZERO: begin
          nxt  = S_IDLE;
          done = 1'b1;
        end
        S_RD00:  nxt = S_RD01;
        S_RD01:  nxt = S_RD10;
        S_RD10:  nxt = S_RD11;
        S_RD11:  nxt = S_CAP;
        S_CAP:   nxt = S_ISSUE;
        S_ISSUE: if (bus.dp_ocupado) nxt = S_WAIT;
        S_WAIT:  if (res_ok) nxt = S_WRITE;
        S_WRITE: nxt = S_NEXT;
        S_NEXT: begin
          if (last_col && last_row) begin
            nxt  = S_IDLE;
            done = 1'b1;
          end else begin
            nxt = S_RD00;
          end
        end
        default: nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_w_q    <= '0;
      src_h_q    <= '0;
      dst_w_q    <= '0;
      dst_h_q    <= '0;
      step_x_q   <= '0;
      step_y_q   <= '0;
      src_base_q <= '0;
      dst_base_q <= '0;
      ox         <= '0;
      oy         <= '0;
      acc_x      <= '0;
      acc_y      <= '0;
      pix        <= '0;
      p00_q      <= '0;
      p01_q      <= '0;
      p10_q      <= '0;
      p11_q      <= '0;
      wr_data_q  <= '0;
    end else if (!abort) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            src_w_q    <= src_w;
            src_h_q    <= src_h;
            dst_w_q    <= dst_w;
            dst_h_q    <= dst_h;
            step_x_q   <= step_x;
            step_y_q   <= step_y;
            src_base_q <= src_base;
            dst_base_q <= dst_base;
            ox         <= '0;
            oy         <= '0;
            acc_x      <= '0;
            acc_y      <= '0;
            pix        <= '0;
          end
        end
        S_RD01: p00_q <= bus.rd_data;
        S_RD10: p01_q <= bus.rd_data;
        S_RD11: p10_q <= bus.rd_data;
        S_CAP:  p11_q <= bus.rd_data;
        S_WAIT: if (res_ok) wr_data_q <= bus.dp_resultado;
        S_NEXT: begin
          if (!(last_col && last_row)) begin
            pix <= pix + ADDR_W'(1);
            if (last_col) begin
              ox    <= '0;
              acc_x <= '0;
              oy    <= oy + DIM_W'(1);
              acc_y <= acc_y + ACC_W'(step_y_q);
            end else begin
              ox    <= ox + DIM_W'(1);
              acc_x <= acc_x + ACC_W'(step_x_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign xmax = src_w_q - DIM_W'(1);
  assign ymax = src_h_q - DIM_W'(1);
  assign ix   = clamp(acc_x[ACC_W-1:FRAC_W], xmax);
  assign iy   = clamp(acc_y[ACC_W-1:FRAC_W], ymax);
  assign x1   = (ix >= xmax) ? xmax : ix + DIM_W'(1);
  assign y1   = (iy >= ymax) ? ymax : iy + DIM_W'(1);

  assign sel_x1 = (state == S_RD01) || (state == S_RD11);
  assign sel_y1 = (state == S_RD10) || (state == S_RD11);
  assign rd_st  = (state == S_RD00) || (state == S_RD01) ||
                  (state == S_RD10) || (state == S_RD11);
  assign rx     = sel_x1 ? x1 : ix;
  assign ry     = sel_y1 ? y1 : iy;
  assign prod   = ry * src_w_q;

  assign busy           = (state != S_IDLE);
  assign bus.rd_en      = rd_st && !abort;
  assign bus.rd_addr    = bus.rd_en ?
                          src_base_q + ADDR_W'(prod) + ADDR_W'(rx) : '0;
  assign bus.wr_en      = (state == S_WRITE) && !abort;
  assign bus.wr_addr    = bus.wr_en ? dst_base_q + pix : '0;
  assign bus.wr_data    = wr_data_q;
  assign bus.dp_iniciar = (state == S_ISSUE) && !abort;
  assign bus.p00        = p00_q;
  assign bus.p01        = p01_q;
  assign bus.p10        = p10_q;
  assign bus.p11        = p11_q;
  assign bus.fx         = acc_x[FRAC_W-1:0];
  assign bus.fy         = acc_y[FRAC_W-1:0];

endmodule

// File: tb/tb_escalado_scan_ctrl.sv
// Directed bench for escalado_scan_ctrl with a memory and datapath model.
// Expected read/write addresses and weights come from hand tables.
module tb_escalado_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [9:0]  src_w = '0, src_h = '0, dst_w = '0, dst_h = '0;
  logic [17:0] step_x = '0, step_y = '0;
  logic [15:0] src_base = '0, dst_base = '0;
  logic        busy, done;

  escalado_scan_ctrl_if bus ();

  escalado_scan_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .src_w    (src_w),
    .src_h    (src_h),
    .dst_w    (dst_w),
    .dst_h    (dst_h),
    .step_x   (step_x),
    .step_y   (step_y),
    .src_base (src_base),
    .dst_base (dst_base),
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [7:0] memf(input int a);
    return 8'((a * 7) ^ (a >> 8));
  endfunction

  // source memory: one cycle read latency
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.rd_data <= '0;
    else if (bus.rd_en) bus.rd_data <= memf(int'(bus.rd_addr));
  end

  // datapath model: optional hold before accepting, then carga + calc
  int hold_cfg = 0;
  int calc_cfg = 0;
  int hold_left;
  int calc_cnt;
  int dp_st;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_st            <= 0;
      hold_left        <= 0;
      calc_cnt         <= 0;
      bus.dp_ocupado   <= 1'b0;
      bus.dp_listo     <= 1'b0;
      bus.dp_resultado <= '0;
    end else begin
      case (dp_st)
        0: if (bus.dp_iniciar) begin
          if (hold_left < hold_cfg) begin
            hold_left <= hold_left + 1;
          end else begin
            hold_left      <= 0;
            dp_st          <= 1;
            bus.dp_ocupado <= 1'b1;
            bus.dp_listo   <= 1'b0;
          end
        end
        1: begin
          dp_st    <= 2;
          calc_cnt <= 0;
        end
        default: begin
          if (calc_cnt >= calc_cfg) begin
            dp_st            <= 0;
            bus.dp_ocupado   <= 1'b0;
            bus.dp_listo     <= 1'b1;
            bus.dp_resultado <= 8'(bus.p00 + bus.p01 + bus.p10 + bus.p11);
          end else begin
            calc_cnt <= calc_cnt + 1;
          end
        end
      endcase
    end
  end

  // monitor
  int rd_q[$];
  int wa_q[$];
  int wd_q[$];
  int fx_q[$];
  int fy_q[$];
  int done_cnt = 0;
  int ini_lo = 0;
  int ini_hi = 0;
  logic ini_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.rd_en) rd_q.push_back(int'(bus.rd_addr));
    if (bus.wr_en) begin
      wa_q.push_back(int'(bus.wr_addr));
      wd_q.push_back(int'(bus.wr_data));
    end
    if (done) done_cnt++;
    if (bus.dp_iniciar && !ini_prev) begin
      fx_q.push_back(int'(bus.fx));
      fy_q.push_back(int'(bus.fy));
    end
    if (bus.dp_iniciar) begin
      if (bus.dp_ocupado) ini_hi++;
      else ini_lo++;
    end
    ini_prev = bus.dp_iniciar;
  end

  int rd0, wr0, f0, dn0, lo0, hi0;

  task automatic snap();
    rd0 = rd_q.size();
    wr0 = wa_q.size();
    f0  = fx_q.size();
    dn0 = done_cnt;
    lo0 = ini_lo;
    hi0 = ini_hi;
  endtask

  task automatic kick(input int sw, sh, dw, dh, stx, sty, sb, db);
    snap();
    @(posedge clk); #1;
    src_w = 10'(sw); src_h = 10'(sh);
    dst_w = 10'(dw); dst_h = 10'(dh);
    step_x = 18'(stx); step_y = 18'(sty);
    src_base = 16'(sb); dst_base = 16'(db);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input string nm,
                           input int sw, sh, dw, dh, stx, sty, sb, db);
    bit got;
    kick(sw, sh, dw, dh, stx, sty, sb, db);
    got = 1'b0;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(posedge clk);
      if (done_cnt > dn0) got = 1'b1;
    end
    if (!got) check({nm, " timeout"}, 0, 1);
    repeat (4) @(posedge clk);
  endtask

  task automatic check_frame(input string nm, input int er[16],
                             input int efx[4], input int efy[4],
                             input int db);
    int v;
    check({nm, " rd count"}, rd_q.size() - rd0, 16);
    for (int i = 0; i < 16; i++) begin
      v = (rd0 + i < rd_q.size()) ? rd_q[rd0 + i] : -1;
      check($sformatf("%s rd[%0d]", nm, i), v, er[i]);
    end
    check({nm, " wr count"}, wa_q.size() - wr0, 4);
    for (int p = 0; p < 4; p++) begin
      v = (wr0 + p < wa_q.size()) ? wa_q[wr0 + p] : -1;
      check($sformatf("%s wr_addr[%0d]", nm, p), v, db + p);
      v = (wr0 + p < wd_q.size()) ? wd_q[wr0 + p] : -1;
      check($sformatf("%s wr_data[%0d]", nm, p), v,
            int'(8'(memf(er[4*p]) + memf(er[4*p+1]) +
                    memf(er[4*p+2]) + memf(er[4*p+3]))));
      v = (f0 + p < fx_q.size()) ? fx_q[f0 + p] : -1;
      check($sformatf("%s fx[%0d]", nm, p), v, efx[p]);
      v = (f0 + p < fy_q.size()) ? fy_q[f0 + p] : -1;
      check($sformatf("%s fy[%0d]", nm, p), v, efy[p]);
    end
    check({nm, " done pulses"}, done_cnt - dn0, 1);
  endtask

  task automatic check_reset(input string nm);
    check({nm, " busy"}, int'(busy), 0);
    check({nm, " done"}, int'(done), 0);
    check({nm, " rd_en"}, int'(bus.rd_en), 0);
    check({nm, " wr_en"}, int'(bus.wr_en), 0);
    check({nm, " iniciar"}, int'(bus.dp_iniciar), 0);
    check({nm, " rd_addr"}, int'(bus.rd_addr), 0);
    check({nm, " wr_data"}, int'(bus.wr_data), 0);
    check({nm, " p00"}, int'(bus.p00), 0);
    check({nm, " fx"}, int'(bus.fx), 0);
  endtask

  int e1[16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
  int e2[16] = '{'h100, 'h101, 'h103, 'h104, 'h101, 'h102, 'h104, 'h105,
                 'h103, 'h104, 'h106, 'h107, 'h104, 'h105, 'h107, 'h108};
  int e3[16] = '{0, 1, 3, 4, 2, 2, 5, 5, 6, 7, 6, 7, 8, 8, 8, 8};
  int z4[4]  = '{0, 0, 0, 0};
  int fx2[4] = '{0, 'h80, 0, 'h80};
  int fy2[4] = '{0, 0, 'h80, 'h80};

  initial begin
    bit got;
    #22;
    check_reset("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_frame("t1", 4, 4, 2, 2, 'h200, 'h200, 0, 0);
    check_frame("t1", e1, z4, z4, 0);
    check("t1 ini_lo", ini_lo - lo0, 4);
    check("t1 ini_hi", ini_hi - hi0, 4);

    run_frame("t2", 3, 3, 2, 2, 'h180, 'h180, 'h100, 'h40);
    check_frame("t2", e2, fx2, fy2, 'h40);

    run_frame("t3", 3, 3, 2, 2, 'h200, 'h200, 0, 0);
    check_frame("t3", e3, z4, z4, 0);

    hold_cfg = 4;
    run_frame("t4", 4, 4, 2, 2, 'h200, 'h200, 0, 0);
    check_frame("t4", e1, z4, z4, 0);
    check("t4 ini_lo", ini_lo - lo0, 20);
    check("t4 ini_hi", ini_hi - hi0, 4);
    hold_cfg = 0;

    run_frame("t5", 4, 4, 0, 2, 'h200, 'h200, 0, 0);
    check("t5 rd", rd_q.size() - rd0, 0);
    check("t5 wr", wa_q.size() - wr0, 0);
    check("t5 done", done_cnt - dn0, 1);

    calc_cfg = 20;
    kick(4, 4, 2, 2, 'h200, 'h200, 0, 0);
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(posedge clk);
      if (ini_hi > hi0) got = 1'b1;
    end
    if (!got) check("t6 reach wait", 0, 1);
    #1;
    abort = 1'b1;
    check("t6 wr during abort", int'(bus.wr_en), 0);
    @(posedge clk); #1;
    abort = 1'b0;
    check("t6 busy after abort", int'(busy), 0);
    repeat (40) @(posedge clk);
    check("t6 no write", wa_q.size() - wr0, 0);
    check("t6 no done", done_cnt - dn0, 0);
    calc_cfg = 0;
    run_frame("t6r", 4, 4, 2, 2, 'h200, 'h200, 0, 0);
    check_frame("t6r", e1, z4, z4, 0);

    kick(4, 4, 2, 2, 'h200, 'h200, 0, 0);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
